ar_req_buffer_mp: RTL and testbench

Multi-port successor to the single-channel AR request buffer. It accepts AXI read-address requests from NUM_PORTS independent masters and queues each port in its own FIFO. A QoS-aware round-robin arbiter merges the queues into one registered AR stream toward the ID remapping unit. The output register is AXI-compliant: payload is held while stalled, and throughput is one request per cycle.

---
 rtl/ar_req_buffer_mp_if.sv | 54 +++++
 rtl/ar_req_buffer_mp.sv | 198 +++++++++++++++++++
 tb/tb_ar_req_buffer_mp.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ar_req_buffer_mp_if.sv
// Multi-port AR request bus: NUM_PORTS packed request channels in, one merged
// AR stream out, plus per-port FIFO occupancy.
//   slave  : seen by the buffer (takes in_*, out_ready; drives in_ready, out_*, level)
//   master : seen by the requesters / downstream model (the opposite directions)
interface ar_req_buffer_mp_if #(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned TAG_WIDTH  = 4,
    parameter int unsigned FIFO_DEPTH = 16
);
    localparam int unsigned PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_PORTS-1:0]            in_valid;
    logic [NUM_PORTS-1:0]            in_ready;
    logic [NUM_PORTS*ID_WIDTH-1:0]   in_id;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] in_addr;
    logic [NUM_PORTS*LEN_WIDTH-1:0]  in_len;
    logic [NUM_PORTS*3-1:0]          in_size;
    logic [NUM_PORTS*2-1:0]          in_burst;
    logic [NUM_PORTS*4-1:0]          in_qos;
    logic [NUM_PORTS*TAG_WIDTH-1:0]  in_tagid;

    logic                            out_valid;
    logic                            out_ready;
    logic [ID_WIDTH-1:0]             out_id;
    logic [ADDR_WIDTH-1:0]           out_addr;
    logic [LEN_WIDTH-1:0]            out_len;
    logic [2:0]                      out_size;
    logic [1:0]                      out_burst;
    logic [3:0]                      out_qos;
    logic [TAG_WIDTH-1:0]            out_tagid;
    logic [PORT_W-1:0]               out_port;

    logic [NUM_PORTS*LVL_W-1:0]      level;

    modport slave (
        input  in_valid, in_id, in_addr, in_len, in_size, in_burst, in_qos, in_tagid,
        input  out_ready,
        output in_ready,
        output out_valid, out_id, out_addr, out_len, out_size, out_burst, out_qos,
        output out_tagid, out_port, level
    );

    modport master (
        output in_valid, in_id, in_addr, in_len, in_size, in_burst, in_qos, in_tagid,
        output out_ready,
        input  in_ready,
        input  out_valid, out_id, out_addr, out_len, out_size, out_burst, out_qos,
        input  out_tagid, out_port, level
    );
endinterface

// File: rtl/ar_req_buffer_mp.sv
// Multi-port AR request buffer: one FIFO per input port, a QoS-aware
// round-robin arbiter over the FIFO heads, and one registered output stage
// that holds its payload while stalled and sustains one request per cycle.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : ar_req_buffer_mp_if.slave (per-port AR inputs, merged AR output,
//              source port of the output, per-port occupancy)
module ar_req_buffer_mp #(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned TAG_WIDTH  = 4,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned QOS_ARB    = 1
) (
    input  logic              clk,
    input  logic              rst,
    ar_req_buffer_mp_if.slave bus
);
    localparam int unsigned PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [LEN_WIDTH-1:0]  len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic [3:0]            qos;
        logic [TAG_WIDTH-1:0]  tagid;
    } req_t;

    req_t             mem_q    [NUM_PORTS][FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q [NUM_PORTS];
    logic [PTR_W-1:0] wr_ptr_d [NUM_PORTS];
    logic [PTR_W-1:0] rd_ptr_q [NUM_PORTS];
    logic [PTR_W-1:0] rd_ptr_d [NUM_PORTS];
    logic [LVL_W-1:0] level_q  [NUM_PORTS];
    logic [LVL_W-1:0] level_d  [NUM_PORTS];

    req_t                 in_req [NUM_PORTS];
    req_t                 head   [NUM_PORTS];
    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] nonempty;
    logic [NUM_PORTS-1:0] cand;
    logic [NUM_PORTS-1:0] push;
    logic [NUM_PORTS-1:0] pop;
    logic [NUM_PORTS-1:0] in_ready_c;
    logic [3:0]           max_qos;
    logic                 found;
    logic [PORT_W-1:0]    winner;
    logic                 load;

    logic              out_valid_q, out_valid_d;
    req_t              out_q, out_d;
    logic [PORT_W-1:0] out_port_q, out_port_d;
    logic [PORT_W-1:0] rr_ptr_q, rr_ptr_d;

    // Unpack per-port request fields and derive FIFO status.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            in_req[p]       = '0;
            in_req[p].id    = bus.in_id[p*ID_WIDTH +: ID_WIDTH];
            in_req[p].addr  = bus.in_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
            in_req[p].len   = bus.in_len[p*LEN_WIDTH +: LEN_WIDTH];
            in_req[p].size  = bus.in_size[p*3 +: 3];
            in_req[p].burst = bus.in_burst[p*2 +: 2];
            in_req[p].qos   = bus.in_qos[p*4 +: 4];
            in_req[p].tagid = bus.in_tagid[p*TAG_WIDTH +: TAG_WIDTH];
            full[p]         = (level_q[p] == LVL_W'(FIFO_DEPTH));
            nonempty[p]     = (level_q[p] != '0);
            head[p]         = mem_q[p][rd_ptr_q[p]];
        end
    end

    // Ready depends only on occupancy; a full FIFO frees up the cycle after its pop.
    assign in_ready_c   = ~full & {NUM_PORTS{~rst}};
    assign bus.in_ready = in_ready_c;

    // Arbiter: optionally keep only max-QoS heads, then first candidate from rr_ptr upward.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        max_qos = '0;
        cand    = '0;
        found   = 1'b0;
        winner  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (nonempty[p] && (head[p].qos > max_qos)) begin
                max_qos = head[p].qos;
            end
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            cand[p] = nonempty[p] && ((QOS_ARB == 0) || (head[p].qos == max_qos));
        end
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            idx = 32'(rr_ptr_q) + i;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            if (!found && cand[PORT_W'(idx)]) begin
                found  = 1'b1;
                winner = PORT_W'(idx);
            end
        end
    end

    // Next state: output stage load/drain and per-port FIFO bookkeeping.
    always_comb begin
        int unsigned nxt;
        nxt         = 0;
        load        = (!out_valid_q || bus.out_ready) && found;
        push        = bus.in_valid & in_ready_c;
        pop         = '0;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        out_port_d  = out_port_q;
        rr_ptr_d    = rr_ptr_q;

        if (load) begin
            pop[winner] = 1'b1;
            out_valid_d = 1'b1;
            out_d       = head[winner];
            out_port_d  = winner;
            nxt         = 32'(winner) + 1;
            if (nxt >= NUM_PORTS) begin
                nxt = 0;
            end
            rr_ptr_d = PORT_W'(nxt);
        end else if (out_valid_q && bus.out_ready) begin
            // Drained with nothing queued: payload keeps its last value.
            out_valid_d = 1'b0;
        end

        for (int p = 0; p < NUM_PORTS; p++) begin
            wr_ptr_d[p] = push[p] ? wr_ptr_q[p] + PTR_W'(1) : wr_ptr_q[p];
            rd_ptr_d[p] = pop[p]  ? rd_ptr_q[p] + PTR_W'(1) : rd_ptr_q[p];
            case ({push[p], pop[p]})
                2'b10:   level_d[p] = level_q[p] + LVL_W'(1);
                2'b01:   level_d[p] = level_q[p] - LVL_W'(1);
                default: level_d[p] = level_q[p];
            endcase
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                wr_ptr_q[p] <= '0;
                rd_ptr_q[p] <= '0;
                level_q[p]  <= '0;
            end
            out_valid_q <= 1'b0;
            out_q       <= '0;
            out_port_q  <= '0;
            rr_ptr_q    <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                wr_ptr_q[p] <= wr_ptr_d[p];
                rd_ptr_q[p] <= rd_ptr_d[p];
                level_q[p]  <= level_d[p];
            end
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            out_port_q  <= out_port_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (push[p]) begin
                mem_q[p][wr_ptr_q[p]] <= in_req[p];
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_id    = out_q.id;
    assign bus.out_addr  = out_q.addr;
    assign bus.out_len   = out_q.len;
    assign bus.out_size  = out_q.size;
    assign bus.out_burst = out_q.burst;
    assign bus.out_qos   = out_q.qos;
    assign bus.out_tagid = out_q.tagid;
    assign bus.out_port  = out_port_q;

    always_comb begin
        bus.level = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            bus.level[p*LVL_W +: LVL_W] = level_q[p];
        end
    end
endmodule

// File: tb/tb_ar_req_buffer_mp.sv
// Testbench for ar_req_buffer_mp (2 ports, depth 16, QoS arbitration on).
// A queue-based reference model predicts every output each cycle; a vector
// table and hand-written sequences add fixed expectations for the key cases.
module tb_ar_req_buffer_mp;
    localparam int unsigned NP  = 2;
    localparam int unsigned IDW = 4;
    localparam int unsigned AW  = 32;
    localparam int unsigned LW  = 8;
    localparam int unsigned TW  = 4;
    localparam int unsigned FD  = 16;
    localparam int unsigned LVW = 5;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  qos;
        logic [3:0]  tag;
    } req_t;

    typedef struct {
        logic [1:0]  v;
        logic [3:0]  q0;
        logic [3:0]  q1;
        logic [31:0] a0;
        logic [31:0] a1;
        logic        ordy;
        logic        e_ov;
        logic        e_port;
        logic [4:0]  e_l0;
        logic [4:0]  e_l1;
        logic [31:0] e_addr;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ar_req_buffer_mp_if #(.NUM_PORTS(NP), .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW),
                          .TAG_WIDTH(TW), .FIFO_DEPTH(FD)) bus ();

    ar_req_buffer_mp #(.NUM_PORTS(NP), .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW),
                       .TAG_WIDTH(TW), .FIFO_DEPTH(FD), .QOS_ARB(1)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int   errors = 0;
    int   checks = 0;

    // Stimulus state
    logic [NP-1:0] t_valid;
    req_t          t_req [NP];
    logic          t_ordy;

    // Reference model state
    req_t        mq [NP][$];
    logic        m_ov;
    req_t        m_out;
    int unsigned m_port;
    int unsigned m_rr;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic req_t mk(input logic [31:0] a, input logic [3:0] q);
        req_t r;
        r.id    = 4'd3;
        r.addr  = a;
        r.len   = 8'd7;
        r.size  = 3'd2;
        r.burst = 2'd1;
        r.qos   = q;
        r.tag   = a[3:0];
        return r;
    endfunction

    function automatic req_t rnd_req();
        req_t r;
        r.id    = 4'($urandom);
        r.addr  = $urandom;
        r.len   = 8'($urandom);
        r.size  = 3'($urandom);
        r.burst = 2'($urandom);
        r.qos   = 4'($urandom_range(0, 3));
        r.tag   = 4'($urandom);
        return r;
    endfunction

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            bus.in_valid[p]              = t_valid[p];
            bus.in_id[p*IDW +: IDW]      = t_req[p].id;
            bus.in_addr[p*AW +: AW]      = t_req[p].addr;
            bus.in_len[p*LW +: LW]       = t_req[p].len;
            bus.in_size[p*3 +: 3]        = t_req[p].size;
            bus.in_burst[p*2 +: 2]       = t_req[p].burst;
            bus.in_qos[p*4 +: 4]         = t_req[p].qos;
            bus.in_tagid[p*TW +: TW]     = t_req[p].tag;
        end
        bus.out_ready = t_ordy;
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) mq[p].delete();
        m_ov   = 1'b0;
        m_out  = '0;
        m_port = 0;
        m_rr   = 0;
    endtask

    // One clock edge of the buffer as described by its rules.
    task automatic model_edge();
        logic [NP-1:0] rdy;
        int unsigned   best;
        int            w;
        for (int p = 0; p < NP; p++) rdy[p] = (mq[p].size() < FD);
        best = 0;
        for (int p = 0; p < NP; p++)
            if (mq[p].size() > 0 && 32'(mq[p][0].qos) > best) best = 32'(mq[p][0].qos);
        w = -1;
        for (int k = 0; k < NP; k++) begin
            int unsigned p;
            p = (m_rr + 32'(k)) % NP;
            if (w < 0 && mq[p].size() > 0 && 32'(mq[p][0].qos) == best) w = int'(p);
        end
        if ((!m_ov || t_ordy) && w >= 0) begin
            m_out  = mq[w].pop_front();
            m_port = 32'(w);
            m_ov   = 1'b1;
            m_rr   = (32'(w) + 1) % NP;
        end else if (m_ov && t_ordy) begin
            m_ov = 1'b0;
        end
        for (int p = 0; p < NP; p++)
            if (t_valid[p] && rdy[p]) mq[p].push_back(t_req[p]);
    endtask

    task automatic compare();
        logic [NP*LVW-1:0] el;
        logic [NP-1:0]     er;
        for (int p = 0; p < NP; p++) begin
            el[p*LVW +: LVW] = LVW'(mq[p].size());
            er[p]            = (mq[p].size() < FD);
        end
        chk("in_ready",  64'(bus.in_ready),  64'(er));
        chk("level",     64'(bus.level),     64'(el));
        chk("out_valid", 64'(bus.out_valid), 64'(m_ov));
        chk("out_port",  64'(bus.out_port),  64'(m_port));
        chk("out_addr",  64'(bus.out_addr),  64'(m_out.addr));
        chk("out_id",    64'(bus.out_id),    64'(m_out.id));
        chk("out_len",   64'(bus.out_len),   64'(m_out.len));
        chk("out_size",  64'(bus.out_size),  64'(m_out.size));
        chk("out_burst", 64'(bus.out_burst), 64'(m_out.burst));
        chk("out_qos",   64'(bus.out_qos),   64'(m_out.qos));
        chk("out_tagid", 64'(bus.out_tagid), 64'(m_out.tag));
    endtask

    task automatic step();
        drive();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic idle_inputs();
        t_valid = '0;
        for (int p = 0; p < NP; p++) t_req[p] = '0;
    endtask

    initial begin
        // Round-robin with equal QoS, QoS preemption, then single-request latency.
        tbl[0]  = '{2'b11, 4'd5, 4'd5, 32'h100,  32'h200, 1'b0, 1'b0, 1'b0, 5'd1, 5'd1, 32'h0};
        tbl[1]  = '{2'b11, 4'd5, 4'd5, 32'h104,  32'h204, 1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 32'h100};
        tbl[2]  = '{2'b00, 4'd0, 4'd0, 32'h0,    32'h0,   1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 32'h100};
        tbl[3]  = '{2'b00, 4'd0, 4'd0, 32'h0,    32'h0,   1'b1, 1'b1, 1'b1, 5'd1, 5'd1, 32'h200};
        tbl[4]  = '{2'b00, 4'd0, 4'd0, 32'h0,    32'h0,   1'b1, 1'b1, 1'b0, 5'd0, 5'd1, 32'h104};
        tbl[5]  = '{2'b00, 4'd0, 4'd0, 32'h0,    32'h0,   1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 32'h204};
        tbl[6]  = '{2'b00, 4'd0, 4'd0, 32'h0,    32'h0,   1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 32'h204};
        tbl[7]  = '{2'b11, 4'd2, 4'd9, 32'h300,  32'h400, 1'b0, 1'b0, 1'b1, 5'd1, 5'd1, 32'h204};
        tbl[8]  = '{2'b11, 4'd2, 4'd2, 32'h304,  32'h404, 1'b0, 1'b1, 1'b1, 5'd2, 5'd1, 32'h400};
        tbl[9]  = '{2'b00, 4'd0, 4'd0, 32'h0,    32'h0,   1'b1, 1'b1, 1'b0, 5'd1, 5'd1, 32'h300};
        tbl[10] = '{2'b00, 4'd0, 4'd0, 32'h0,    32'h0,   1'b1, 1'b1, 1'b1, 5'd1, 5'd0, 32'h404};
        tbl[11] = '{2'b00, 4'd0, 4'd0, 32'h0,    32'h0,   1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 32'h304};
        tbl[12] = '{2'b00, 4'd0, 4'd0, 32'h0,    32'h0,   1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 32'h304};
        tbl[13] = '{2'b01, 4'd0, 4'd0, 32'h1000, 32'h0,   1'b1, 1'b0, 1'b0, 5'd1, 5'd0, 32'h304};
        tbl[14] = '{2'b00, 4'd0, 4'd0, 32'h0,    32'h0,   1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 32'h1000};
        tbl[15] = '{2'b00, 4'd0, 4'd0, 32'h0,    32'h0,   1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 32'h1000};

        rst    = 1'b1;
        t_ordy = 1'b0;
        idle_inputs();
        drive();
        model_reset();
        #12;
        chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
        chk("rst_level",     64'(bus.level),     64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_port",  64'(bus.out_port),  64'd0);
        chk("rst_out_addr",  64'(bus.out_addr),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 64'(bus.in_ready), 64'd3);

        // Vector table
        for (int i = 0; i < 16; i++) begin
            t_valid  = tbl[i].v;
            t_req[0] = mk(tbl[i].a0, tbl[i].q0);
            t_req[1] = mk(tbl[i].a1, tbl[i].q1);
            t_ordy   = tbl[i].ordy;
            step();
            chk($sformatf("vec%0d_out_valid", i), 64'(bus.out_valid),   64'(tbl[i].e_ov));
            chk($sformatf("vec%0d_out_port", i),  64'(bus.out_port),    64'(tbl[i].e_port));
            chk($sformatf("vec%0d_level0", i),    64'(bus.level[4:0]),  64'(tbl[i].e_l0));
            chk($sformatf("vec%0d_level1", i),    64'(bus.level[9:5]),  64'(tbl[i].e_l1));
            chk($sformatf("vec%0d_out_addr", i),  64'(bus.out_addr),    64'(tbl[i].e_addr));
            chk($sformatf("vec%0d_in_ready", i),  64'(bus.in_ready),    64'd3);
        end

        // Backpressure: 0xA0 held for 5 stalled cycles with two more queued behind it
        idle_inputs();
        t_ordy = 1'b0;
        t_valid = 2'b01; t_req[0] = mk(32'hA0, 4'd0); step();
        t_req[0] = mk(32'hB0, 4'd0); step();
        t_req[0] = mk(32'hB4, 4'd0); step();
        t_valid = '0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_out_valid", 64'(bus.out_valid),  64'd1);
            chk("stall_out_addr",  64'(bus.out_addr),   64'hA0);
            chk("stall_level0",    64'(bus.level[4:0]), 64'd2);
        end
        t_ordy = 1'b1;
        for (int i = 0; i < 4; i++) step();

        // Fill port 1 to full behind a stalled output, then drain in order
        t_ordy = 1'b0;
        t_valid = 2'b01; t_req[0] = mk(32'hC0, 4'd0); step();
        t_valid = '0; step();
        t_valid = 2'b10;
        for (int i = 0; i < 16; i++) begin
            t_req[1] = mk(32'(i), 4'd0);
            step();
        end
        chk("full_level1",    64'(bus.level[9:5]), 64'd16);
        chk("full_in_ready1", 64'(bus.in_ready[1]), 64'd0);
        t_req[1] = mk(32'd99, 4'd0);
        step();
        chk("full_reject_level1", 64'(bus.level[9:5]), 64'd16);
        t_valid = '0;
        t_ordy  = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step();
            chk("drain_out_valid", 64'(bus.out_valid), 64'd1);
            chk("drain_out_port",  64'(bus.out_port),  64'd1);
            chk("drain_out_addr",  64'(bus.out_addr),  64'(k));
            if (k == 0) begin
                chk("drain_in_ready1", 64'(bus.in_ready[1]), 64'd1);
                chk("drain_level1",    64'(bus.level[9:5]),  64'd15);
            end
        end
        step();
        chk("drain_end_valid", 64'(bus.out_valid), 64'd0);

        // Reset in the middle of traffic discards everything
        t_ordy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            t_valid  = (i < 3) ? 2'b11 : 2'b10;
            t_req[0] = rnd_req();
            t_req[1] = rnd_req();
            step();
        end
        chk("pre_rst_out_valid", 64'(bus.out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_level",     64'(bus.level),     64'd0);
        chk("mid_rst_in_ready",  64'(bus.in_ready),  64'd0);
        chk("mid_rst_out_addr",  64'(bus.out_addr),  64'd0);
        model_reset();
        idle_inputs();
        drive();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd3);
        t_ordy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("post_rst_no_stale", 64'(bus.out_valid), 64'd0);
        end

        // Randomised traffic against the model, with varying drain rates
        for (int seg = 0; seg < 12; seg++) begin
            int unsigned rpct;
            rpct = (seg % 3 == 0) ? 10 : ((seg % 3 == 1) ? 70 : 100);
            for (int i = 0; i < 50; i++) begin
                for (int p = 0; p < NP; p++) begin
                    t_valid[p] = ($urandom_range(0, 99) < 60);
                    t_req[p]   = rnd_req();
                end
                t_ordy = ($urandom_range(0, 99) < rpct);
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
